// File: rtl/dram_app_bram_responder_pkg.sv
// Shared DRAM app-interface definitions for the capture core and its BRAM-backed responder.
//   DRAM_CMD_WRITE / DRAM_CMD_READ : app_cmd encodings understood by the responder
//   dram_cmd_t                     : app_cmd type
//   DRAM_APP_DATA_WIDTH / _MASK_WIDTH : one BL8 burst on the 4:1 UI and its byte mask
//   DRAM_BURST_ADDR_SHIFT          : app_addr bits below the burst index (always zero)
package f9pcap_dram_pkg;

  typedef logic [2:0] dram_cmd_t;

  localparam dram_cmd_t DRAM_CMD_WRITE = 3'b000;
  localparam dram_cmd_t DRAM_CMD_READ  = 3'b001;

  localparam int unsigned DRAM_APP_DATA_WIDTH   = 512;
  localparam int unsigned DRAM_APP_MASK_WIDTH   = DRAM_APP_DATA_WIDTH / 8;
  localparam int unsigned DRAM_BURST_ADDR_SHIFT = 3;

endpackage

// File: rtl/dram_app_bram_responder_if.sv
// MIG 7-series UI (app_*) bundle between the DRAM initiator (master) and a target (slave).
//   init_calib_complete        : target calibrated, ready may assert
//   app_addr/app_cmd/app_en/app_rdy : command channel
//   app_wdf_*                  : write-data channel, app_wdf_end must mirror app_wdf_wren
//   app_rd_data*               : read-return channel, no backpressure
interface dram_app_bram_responder_if
  import f9pcap_dram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = DRAM_APP_DATA_WIDTH,
  parameter int unsigned MASK_WIDTH = DRAM_APP_MASK_WIDTH,
  parameter int unsigned CMD_WIDTH  = 3
) ();

  logic                                        init_calib_complete;
  logic [ADDR_WIDTH+DRAM_BURST_ADDR_SHIFT-1:0] app_addr;
  logic [CMD_WIDTH-1:0]                        app_cmd;
  logic                                        app_en;
  logic                                        app_rdy;
  logic [DATA_WIDTH-1:0]                       app_wdf_data;
  logic [MASK_WIDTH-1:0]                       app_wdf_mask;
  logic                                        app_wdf_wren;
  logic                                        app_wdf_end;
  logic                                        app_wdf_rdy;
  logic [DATA_WIDTH-1:0]                       app_rd_data;
  logic                                        app_rd_data_valid;
  logic                                        app_rd_data_end;

  modport master (
    input  init_calib_complete, app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
           app_rd_data_end,
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end
  );

  modport slave (
    output init_calib_complete, app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
           app_rd_data_end,
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end
  );

endinterface

// File: rtl/dram_app_rsp_fifo.sv
// Synchronous first-word-fall-through FIFO used for the responder's command and write-data queues.
//   clk, rst_n          : clock, asynchronous active-low reset (flushes pointers only)
//   push, push_data     : enqueue, ignored while full
//   full                : no free entry
//   pop, pop_data       : dequeue; pop_data shows the head whenever not empty
//   empty               : no valid entry
// DEPTH must be a power of two, at least 2.
module dram_app_rsp_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty
);

  localparam int unsigned PtrWidth = $clog2(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [PtrWidth:0] wr_ptr_q, rd_ptr_q;

  // Extra pointer MSB tells full from empty when the index bits match.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PtrWidth] != rd_ptr_q[PtrWidth]) &&
                    (wr_ptr_q[PtrWidth-1:0] == rd_ptr_q[PtrWidth-1:0]);
  assign pop_data = mem_q[rd_ptr_q[PtrWidth-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push && !full) wr_ptr_q <= wr_ptr_q + (PtrWidth + 1)'(1);
      if (pop && !empty) rd_ptr_q <= rd_ptr_q + (PtrWidth + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_ptr_q[PtrWidth-1:0]] <= push_data;
  end

endmodule

// File: rtl/dram_app_bram_responder.sv
// BRAM-backed stand-in for the MIG 7-series UI target, used when the DRAM buffer is disabled or
// in simulation. Commands and write data are queued independently and executed strictly in order,
// one per cycle; reads return through an RD_LATENCY-deep pipe.
//   dram_clk, dram_rst_n : UI clock, asynchronous active-low reset (RAM contents survive reset)
//   app                  : slave side of the app_* bundle, including init_calib_complete
//   protocol_err         : sticky; bad cmd, misaligned addr, or wren without end
// Optional build macro DRAM_APP_RSP_THROTTLE_EN: an LFSR randomly withholds app_rdy and
// app_wdf_rdy (about 25% each) to stress the initiator.
module dram_app_bram_responder
  import f9pcap_dram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned DATA_WIDTH   = DRAM_APP_DATA_WIDTH,
  parameter int unsigned MASK_WIDTH   = DRAM_APP_MASK_WIDTH,
  parameter int unsigned CMD_WIDTH    = 3,
  parameter int unsigned CALIB_CYCLES = 64,
  parameter int unsigned RD_LATENCY   = 4,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                       dram_clk,
  input  logic                       dram_rst_n,
  dram_app_bram_responder_if.slave   app,
  output logic                       protocol_err
);

  localparam int unsigned CmdqWidth     = CMD_WIDTH + ADDR_WIDTH;
  localparam int unsigned WdfqWidth     = DATA_WIDTH + MASK_WIDTH;
  localparam int unsigned CalibCntWidth = $clog2(CALIB_CYCLES + 1);
  localparam int unsigned RamDepth      = 1 << ADDR_WIDTH;
  localparam int unsigned AddrHi        = ADDR_WIDTH + DRAM_BURST_ADDR_SHIFT - 1;

  // Calibration timer
  logic [CalibCntWidth-1:0] calib_cnt_q;
  logic                     calib_q;

  always_ff @(posedge dram_clk or negedge dram_rst_n) begin
    if (!dram_rst_n) begin
      calib_cnt_q <= '0;
      calib_q     <= 1'b0;
    end else if (!calib_q) begin
      if (calib_cnt_q == CalibCntWidth'(CALIB_CYCLES - 1)) calib_q <= 1'b1;
      else calib_cnt_q <= calib_cnt_q + CalibCntWidth'(1);
    end
  end

  assign app.init_calib_complete = calib_q;

  // Ready generation
  logic cmdq_full, cmdq_empty, cmdq_pop;
  logic wdfq_full, wdfq_empty, wdfq_pop;
  logic rdy_gate, wdf_rdy_gate;
  logic cmd_rdy, wdf_rdy, cmd_push, wdf_push;

`ifdef DRAM_APP_RSP_THROTTLE_EN
  logic [15:0] lfsr_q;

  // Fibonacci LFSR, taps 16,14,13,11; each gate is low only when both sampled bits are 0.
  always_ff @(posedge dram_clk or negedge dram_rst_n) begin
    if (!dram_rst_n) lfsr_q <= 16'hACE1;
    else lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign rdy_gate     = lfsr_q[0] | lfsr_q[1];
  assign wdf_rdy_gate = lfsr_q[8] | lfsr_q[9];
`else
  assign rdy_gate     = 1'b1;
  assign wdf_rdy_gate = 1'b1;
`endif

  assign cmd_rdy         = calib_q & ~cmdq_full & rdy_gate;
  assign wdf_rdy         = calib_q & ~wdfq_full & wdf_rdy_gate;
  assign app.app_rdy     = cmd_rdy;
  assign app.app_wdf_rdy = wdf_rdy;
  assign cmd_push        = app.app_en & cmd_rdy;
  assign wdf_push        = app.app_wdf_wren & wdf_rdy;

  // Protocol checking on accepted transfers
  logic cmd_bad, addr_bad, wdf_bad, protocol_err_q;

  assign cmd_bad  = cmd_push && (app.app_cmd != CMD_WIDTH'(DRAM_CMD_WRITE)) &&
                    (app.app_cmd != CMD_WIDTH'(DRAM_CMD_READ));
  assign addr_bad = cmd_push && (|app.app_addr[DRAM_BURST_ADDR_SHIFT-1:0]);
  assign wdf_bad  = wdf_push && !app.app_wdf_end;

  always_ff @(posedge dram_clk or negedge dram_rst_n) begin
    if (!dram_rst_n) protocol_err_q <= 1'b0;
    else protocol_err_q <= protocol_err_q | cmd_bad | addr_bad | wdf_bad;
  end

  assign protocol_err = protocol_err_q;

  // Queues
  logic [CmdqWidth-1:0]  cmdq_head;
  logic [WdfqWidth-1:0]  wdfq_head;
  logic [CMD_WIDTH-1:0]  head_cmd;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;
  logic [MASK_WIDTH-1:0] head_mask;

  dram_app_rsp_fifo #(
    .WIDTH (CmdqWidth),
    .DEPTH (FIFO_DEPTH)
  ) u_cmdq (
    .clk       (dram_clk),
    .rst_n     (dram_rst_n),
    .push      (cmd_push),
    .push_data ({app.app_cmd, app.app_addr[AddrHi:DRAM_BURST_ADDR_SHIFT]}),
    .full      (cmdq_full),
    .pop       (cmdq_pop),
    .pop_data  (cmdq_head),
    .empty     (cmdq_empty)
  );

  dram_app_rsp_fifo #(
    .WIDTH (WdfqWidth),
    .DEPTH (FIFO_DEPTH)
  ) u_wdfq (
    .clk       (dram_clk),
    .rst_n     (dram_rst_n),
    .push      (wdf_push),
    .push_data ({app.app_wdf_data, app.app_wdf_mask}),
    .full      (wdfq_full),
    .pop       (wdfq_pop),
    .pop_data  (wdfq_head),
    .empty     (wdfq_empty)
  );

  assign head_cmd  = cmdq_head[CmdqWidth-1 -: CMD_WIDTH];
  assign head_addr = cmdq_head[ADDR_WIDTH-1:0];
  assign head_data = wdfq_head[WdfqWidth-1 -: DATA_WIDTH];
  assign head_mask = wdfq_head[MASK_WIDTH-1:0];

  // Executor: a head write stalls the whole command stream until its data beat arrives.
  logic ram_we, ram_re;

  always_comb begin
    cmdq_pop = 1'b0;
    wdfq_pop = 1'b0;
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    if (!cmdq_empty) begin
      if (head_cmd == CMD_WIDTH'(DRAM_CMD_WRITE)) begin
        if (!wdfq_empty) begin
          cmdq_pop = 1'b1;
          wdfq_pop = 1'b1;
          ram_we   = 1'b1;
        end
      end else if (head_cmd == CMD_WIDTH'(DRAM_CMD_READ)) begin
        cmdq_pop = 1'b1;
        ram_re   = 1'b1;
      end else begin
        cmdq_pop = 1'b1;  // unknown command is dropped
      end
    end
  end

  // Burst RAM; no reset so contents persist across dram_rst_n.
  logic [DATA_WIDTH-1:0] ram_q [RamDepth];
  logic [DATA_WIDTH-1:0] ram_rd_q;

  always_ff @(posedge dram_clk) begin
    if (ram_we) begin
      for (int b = 0; b < MASK_WIDTH; b++) begin
        if (!head_mask[b]) ram_q[head_addr][b*8 +: 8] <= head_data[b*8 +: 8];
      end
    end
    if (ram_re) ram_rd_q <= ram_q[head_addr];
  end

  // Read return pipe: RAM output register is stage 0, the rest are resettable and zero when idle.
  logic [RD_LATENCY-1:0] rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q [RD_LATENCY-1];

  always_ff @(posedge dram_clk or negedge dram_rst_n) begin
    if (!dram_rst_n) begin
      rd_valid_q <= '0;
      for (int i = 0; i < RD_LATENCY - 1; i++) rd_data_q[i] <= '0;
    end else begin
      rd_valid_q   <= {rd_valid_q[RD_LATENCY-2:0], ram_re};
      rd_data_q[0] <= rd_valid_q[0] ? ram_rd_q : '0;
      for (int i = 1; i < RD_LATENCY - 1; i++) rd_data_q[i] <= rd_data_q[i-1];
    end
  end

  assign app.app_rd_data       = rd_data_q[RD_LATENCY-2];
  assign app.app_rd_data_valid = rd_valid_q[RD_LATENCY-1];
  assign app.app_rd_data_end   = rd_valid_q[RD_LATENCY-1];

endmodule

// File: tb/tb_dram_app_bram_responder.sv
// Bench for dram_app_bram_responder: directed steps plus a randomized phase, checked against a
// burst-array memory model and an expected-read queue.
module tb_dram_app_bram_responder;
  import f9pcap_dram_pkg::*;

  localparam int unsigned AW     = 10;
  localparam int unsigned DW     = 512;
  localparam int unsigned MW     = 64;
  localparam int unsigned CW     = 3;
  localparam int unsigned CALIB  = 64;
  localparam int unsigned LAT    = 4;
  localparam int unsigned FD     = 4;
  localparam int          BUDGET = 400;

  logic dram_clk   = 1'b0;
  logic dram_rst_n = 1'b0;
  logic protocol_err;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  dram_app_bram_responder_if #(
    .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .MASK_WIDTH (MW), .CMD_WIDTH (CW)
  ) app ();

  dram_app_bram_responder #(
    .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .MASK_WIDTH (MW), .CMD_WIDTH (CW),
    .CALIB_CYCLES (CALIB), .RD_LATENCY (LAT), .FIFO_DEPTH (FD)
  ) dut (
    .dram_clk     (dram_clk),
    .dram_rst_n   (dram_rst_n),
    .app          (app),
    .protocol_err (protocol_err)
  );

  always #5 dram_clk = ~dram_clk;
  always @(posedge dram_clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            cyc;
  } beat_t;

  beat_t         rd_q [$];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] model [1 << AW];

  always @(negedge dram_clk) begin
    if (app.app_rd_data_valid === 1'b1)
      rd_q.push_back('{app.app_rd_data, app.app_rd_data_end, cyc});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic void model_write(input logic [AW-1:0] idx, input logic [DW-1:0] d,
                                      input logic [MW-1:0] m);
    for (int b = 0; b < MW; b++) if (!m[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge dram_clk);
  endtask

  // Called on a negedge; returns on the negedge after the accepting posedge.
  task automatic send_cmd(input logic [CW-1:0] c, input logic [AW+2:0] a, output int acc);
    int n = 0;
    app.app_en = 1'b1; app.app_cmd = c; app.app_addr = a;
    while (app.app_rdy !== 1'b1 && n < BUDGET) begin @(negedge dram_clk); n++; end
    check("cmd_handshake", n < BUDGET, 1);
    @(negedge dram_clk);
    app.app_en = 1'b0;
    acc = cyc;
  endtask

  task automatic send_wdf(input logic [DW-1:0] d, input logic [MW-1:0] m, input logic e);
    int n = 0;
    app.app_wdf_wren = 1'b1; app.app_wdf_end = e; app.app_wdf_data = d; app.app_wdf_mask = m;
    while (app.app_wdf_rdy !== 1'b1 && n < BUDGET) begin @(negedge dram_clk); n++; end
    check("wdf_handshake", n < BUDGET, 1);
    @(negedge dram_clk);
    app.app_wdf_wren = 1'b0; app.app_wdf_end = 1'b0;
  endtask

  task automatic write_op(input logic [AW-1:0] idx, input logic [DW-1:0] d,
                          input logic [MW-1:0] m, input logic lead);
    int acc;
    if (lead) begin
      send_wdf(d, m, 1'b1);
      send_cmd(DRAM_CMD_WRITE, {idx, 3'b000}, acc);
    end else begin
      send_cmd(DRAM_CMD_WRITE, {idx, 3'b000}, acc);
      send_wdf(d, m, 1'b1);
    end
    model_write(idx, d, m);
  endtask

  task automatic read_op(input logic [AW-1:0] idx, output int acc);
    send_cmd(DRAM_CMD_READ, {idx, 3'b000}, acc);
    exp_q.push_back(model[idx]);
  endtask

  task automatic drain(output int first_cyc, output int last_cyc);
    int n = 0;
    while (rd_q.size() < exp_q.size() && n < BUDGET) begin @(negedge dram_clk); n++; end
    wait_cycles(2);
    check("beat_count", rd_q.size(), exp_q.size());
    first_cyc = (rd_q.size() > 0) ? rd_q[0].cyc : -1;
    last_cyc  = (rd_q.size() > 0) ? rd_q[rd_q.size()-1].cyc : -1;
    while (rd_q.size() > 0 && exp_q.size() > 0) begin
      beat_t         b;
      logic [DW-1:0] e;
      b = rd_q.pop_front();
      e = exp_q.pop_front();
      check("rd_data", b.data, e);
      check("rd_end", b.last, 1);
    end
    rd_q.delete();
    exp_q.delete();
  endtask

  // Asserts reset immediately, checks the reset state, then times calibration.
  task automatic do_reset();
    int n = 0;
    dram_rst_n = 1'b0;
    wait_cycles(3);
    check("rst_calib", app.init_calib_complete, 0);
    check("rst_rdy", app.app_rdy, 0);
    check("rst_wdf_rdy", app.app_wdf_rdy, 0);
    check("rst_valid", app.app_rd_data_valid, 0);
    check("rst_rd_end", app.app_rd_data_end, 0);
    check("rst_rd_data", app.app_rd_data, 0);
    check("rst_err", protocol_err, 0);
    dram_rst_n = 1'b1;
    while (app.init_calib_complete !== 1'b1 && n < BUDGET) begin
      if (n == int'(CALIB) - 1) check("rdy_before_calib", app.app_rdy, 0);
      @(negedge dram_clk);
      n++;
    end
    check("calib_latency", n, CALIB);
    check("rdy_after_calib", app.app_rdy, 1);
    check("wdf_rdy_after_calib", app.app_wdf_rdy, 1);
  endtask

  initial begin
    int            acc, fc, lc;
    logic [DW-1:0] d, e3;
    logic [DW-1:0] dd [4];
    logic [AW-1:0] addrs [4];
    logic [AW-1:0] ridx [8];
    logic [MW-1:0] m;

    app.app_en = 1'b0; app.app_cmd = '0; app.app_addr = '0;
    app.app_wdf_wren = 1'b0; app.app_wdf_end = 1'b0;
    app.app_wdf_data = '0; app.app_wdf_mask = '0;

    // Reset and calibration timing
    do_reset();

    // Full write then read of byte address 0x40, with latency
    d = {8{64'h0123_4567_89AB_CDEF}};
    write_op(10'd8, d, '0, 1'b0);
    wait_cycles(3);
    read_op(10'd8, acc);
    drain(fc, lc);
    check("rd_latency", fc - acc, LAT);

    // Masked write: only the low 4 bytes take zeros
    write_op(10'd20, '1, '0, 1'b0);
    write_op(10'd20, '0, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0);
    e3 = {{(DW-32){1'b1}}, 32'h0};
    send_cmd(DRAM_CMD_READ, {10'd20, 3'b000}, acc);
    exp_q.push_back(e3);
    drain(fc, lc);

    // Write commands ahead of their data fill the command queue; then back-to-back reads
    for (int i = 0; i < 4; i++) addrs[i] = AW'(100 + 37 * i + $urandom_range(0, 30));
    for (int i = 0; i < 4; i++) send_cmd(DRAM_CMD_WRITE, {addrs[i], 3'b000}, acc);
    check("rdy_cmdq_full", app.app_rdy, 0);
    check("wdf_rdy_while_cmdq_full", app.app_wdf_rdy, 1);
    wait_cycles(3);
    check("rdy_still_full", app.app_rdy, 0);
    for (int i = 0; i < 4; i++) begin
      dd[i] = rand_data();
      send_wdf(dd[i], '0, 1'b1);
      model_write(addrs[i], dd[i], '0);
    end
    for (int j = 0; j < 8; j++) read_op(addrs[j % 4], acc);
    drain(fc, lc);
    check("b2b_read_span", lc - fc, 7);

    // Unknown command: flagged, dropped, RAM untouched
    check("err_clean", protocol_err, 0);
    send_cmd(3'b010, {10'd8, 3'b000}, acc);
    wait_cycles(2);
    check("err_badcmd", protocol_err, 1);
    read_op(10'd8, acc);
    drain(fc, lc);
    wait_cycles(5);
    check("err_sticky", protocol_err, 1);
    check("no_extra_beats", rd_q.size(), 0);
    do_reset();
    check("err_cleared", protocol_err, 0);

    // Misaligned address: low bits ignored
    send_cmd(DRAM_CMD_READ, 13'h041, acc);
    exp_q.push_back(model[8]);
    drain(fc, lc);
    check("err_misalign", protocol_err, 1);
    do_reset();

    // wren without end: flagged, beat still written
    d = rand_data();
    send_cmd(DRAM_CMD_WRITE, {10'd30, 3'b000}, acc);
    send_wdf(d, '0, 1'b0);
    model_write(10'd30, d, '0);
    wait_cycles(2);
    check("err_noend", protocol_err, 1);
    read_op(10'd30, acc);
    drain(fc, lc);

    // Reset with reads in flight: no beats, RAM retained
    do_reset();
    send_cmd(DRAM_CMD_READ, {10'd8, 3'b000}, acc);
    send_cmd(DRAM_CMD_READ, {10'd20, 3'b000}, acc);
    send_cmd(DRAM_CMD_READ, {addrs[0], 3'b000}, acc);
    do_reset();
    check("no_beats_across_reset", rd_q.size(), 0);
    read_op(10'd8, acc);
    read_op(10'd20, acc);
    for (int i = 0; i < 4; i++) read_op(addrs[i], acc);
    read_op(10'd30, acc);
    drain(fc, lc);

    // Randomized mix of reads and masked writes, data leading or lagging its command
    for (int i = 0; i < 8; i++) begin
      ridx[i] = AW'($urandom_range(0, (1 << AW) - 1));
      write_op(ridx[i], rand_data(), '0, 1'($urandom_range(0, 1)));
    end
    for (int k = 0; k < 40; k++) begin
      int unsigned sel;
      sel = $urandom_range(0, 7);
      if ($urandom_range(0, 2) == 0) begin
        m = {$urandom, $urandom};
        write_op(ridx[sel], rand_data(), m, 1'($urandom_range(0, 1)));
      end else begin
        read_op(ridx[sel], acc);
      end
    end
    drain(fc, lc);
    check("err_random_clean", protocol_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
